// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder: Gray-code states, direction levels, FSM encoding,
// and the helpers that give the legal successor of a state in each direction.
package quad_pkg;

    // {A,B} states; the up sequence is 00 -> 10 -> 11 -> 01 -> 00 (A leads B)
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } quad_fsm_t;

    function automatic logic [1:0] quad_next_up(input logic [1:0] s);
        case (s)
            QS_00:   return QS_10;
            QS_10:   return QS_11;
            QS_11:   return QS_01;
            default: return QS_00;
        endcase
    endfunction

    function automatic logic [1:0] quad_next_down(input logic [1:0] s);
        case (s)
            QS_00:   return QS_01;
            QS_01:   return QS_11;
            QS_11:   return QS_10;
            default: return QS_00;
        endcase
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser for an asynchronous input; output lags the input by
// SYNC_STAGES edges and all stages clear on reset.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature front end: synchronises A/B, decodes Gray-code steps into step/up_down pulses,
// keeps a wrap-around position and a sticky flag for double-bit (illegal) transitions.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int POS_WIDTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 quad_a,
    input  logic                 quad_b,
    input  logic                 clear,
    input  logic                 error_clear,
    output logic                 step,
    output logic                 up_down,
    output logic [POS_WIDTH-1:0] position,
    output logic                 error
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1) + 1;

    logic                 w_sync_a;
    logic                 w_sync_b;
    logic [1:0]           w_cur;
    logic [1:0]           r_prev;
    quad_fsm_t            r_state;
    quad_fsm_t            w_state_next;
    logic [CNT_W-1:0]     r_arm_cnt;
    logic                 w_arm_last;
    logic                 w_decode_en;
    logic                 w_up;
    logic                 w_down;
    logic                 w_illegal;
    logic                 r_step;
    logic                 r_up_down;
    logic [POS_WIDTH-1:0] r_position;
    logic                 r_error;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clock   (clock),
        .reset   (reset),
        .i_async (quad_a),
        .o_sync  (w_sync_a)
    );

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clock   (clock),
        .reset   (reset),
        .i_async (quad_b),
        .o_sync  (w_sync_b)
    );

    assign w_cur = {w_sync_a, w_sync_b};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ARM spans SYNC_STAGES+1 edges: enough for the cleared synchronisers and prev to hold real input
    always_comb begin
        w_state_next = r_state;
        w_arm_last   = 1'b0;
        w_decode_en  = 1'b0;
        case (r_state)
            ST_ARM: begin
                w_arm_last = (r_arm_cnt == CNT_W'(SYNC_STAGES));
                if (w_arm_last) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_decode_en = 1'b1;
            end
            default: begin
                w_state_next = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if (r_state == ST_ARM && !w_arm_last) begin
            r_arm_cnt <= r_arm_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_up      = w_decode_en && (w_cur == quad_next_up(r_prev));
        w_down    = w_decode_en && (w_cur == quad_next_down(r_prev));
        w_illegal = w_decode_en && (w_cur != r_prev) && !w_up && !w_down;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev     <= QS_00;
            r_step     <= 1'b0;
            r_up_down  <= DIR_UP;
            r_position <= '0;
            r_error    <= 1'b0;
        end else begin
            r_prev <= w_cur;
            r_step <= w_up || w_down;
            if (w_up) begin
                r_up_down <= DIR_UP;
            end else if (w_down) begin
                r_up_down <= DIR_DOWN;
            end
            if (clear) begin
                r_position <= '0;
            end else if (w_up) begin
                r_position <= r_position + POS_WIDTH'(1);
            end else if (w_down) begin
                r_position <= r_position - POS_WIDTH'(1);
            end
            // a new illegal transition outranks a simultaneous clear request
            if (w_illegal) begin
                r_error <= 1'b1;
            end else if (error_clear) begin
                r_error <= 1'b0;
            end
        end
    end

    assign step     = r_step;
    assign up_down  = r_up_down;
    assign position = r_position;
    assign error    = r_error;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed scenarios followed by a random walk, every cycle compared against a phase-arithmetic model.
module tb_quadrature_decoder;

    localparam int S  = 2;
    localparam int PW = 4;
    localparam int PMASK = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          quad_a = 1'b0;
    logic          quad_b = 1'b0;
    logic          clear = 1'b0;
    logic          error_clear = 1'b0;
    logic          step;
    logic          up_down;
    logic [PW-1:0] position;
    logic          error;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [1:0] hist[$];
    int         n_since_reset = 0;
    logic       m_step = 1'b0;
    logic       m_dir = 1'b1;
    int         m_pos = 0;
    logic       m_err = 1'b0;
    logic [1:0] cur_ab = 2'b00;
    int         step_seen = 0;

    quadrature_decoder #(.SYNC_STAGES(S), .POS_WIDTH(PW)) dut (
        .clock       (clock),
        .reset       (reset),
        .quad_a      (quad_a),
        .quad_b      (quad_b),
        .clear       (clear),
        .error_clear (error_clear),
        .step        (step),
        .up_down     (up_down),
        .position    (position),
        .error       (error)
    );

    always #5 clock = ~clock;

    // quadrature phase of an {A,B} pair along the up direction
    function automatic int phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // input sampled at edge j after reset (edges before the first count as 0)
    function automatic logic [1:0] sample_at(input int j);
        if (j < 1) return 2'b00;
        return hist[j-1];
    endfunction

    task automatic model_edge(input logic rst, input logic [1:0] ab, input logic clr, input logic eclr);
        int d;
        logic lg_up, lg_dn, ill;
        if (rst) begin
            hist.delete();
            n_since_reset = 0;
            m_step = 1'b0; m_dir = 1'b1; m_pos = 0; m_err = 1'b0;
            return;
        end
        n_since_reset++;
        hist.push_back(ab);
        lg_up = 1'b0; lg_dn = 1'b0; ill = 1'b0;
        if (n_since_reset >= S + 2) begin
            d = (phase(sample_at(n_since_reset - S)) - phase(sample_at(n_since_reset - S - 1))) & 3;
            lg_up = (d == 1);
            lg_dn = (d == 3);
            ill   = (d == 2);
        end
        m_step = lg_up | lg_dn;
        if (lg_up) begin m_dir = 1'b1; m_pos = (m_pos + 1) & PMASK; end
        if (lg_dn) begin m_dir = 1'b0; m_pos = (m_pos - 1) & PMASK; end
        if (clr) m_pos = 0;
        if (ill) m_err = 1'b1;
        else if (eclr) m_err = 1'b0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("step", int'(step), int'(m_step));
        check("up_down", int'(up_down), int'(m_dir));
        check("position", int'(position), m_pos);
        check("error", int'(error), m_err);
    endtask

    task automatic tick(input logic [1:0] ab, input logic clr, input logic eclr);
        {quad_a, quad_b} = ab;
        clear = clr;
        error_clear = eclr;
        cur_ab = ab;
        @(posedge clock);
        model_edge(reset, ab, clr, eclr);
        #1;
        if (step === 1'b1) step_seen++;
        check_all();
        clear = 1'b0;
        error_clear = 1'b0;
    endtask

    task automatic go(input logic [1:0] ab, input int hold);
        for (int i = 0; i < hold; i++) tick(ab, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick(cur_ab, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    function automatic logic [1:0] succ(input logic [1:0] ab, input int delta);
        logic [1:0] tbl [4];
        tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
        return tbl[(phase(ab) + delta) & 3];
    endfunction

    initial begin
        // reset state, then idle at 00
        do_reset(2);
        check("reset_pos", int'(position), 0);
        check("reset_dir", int'(up_down), 1);
        step_seen = 0;
        go(2'b00, 10);
        check("idle_steps", step_seen, 0);
        check("idle_err", int'(error), 0);

        // one full up cycle, one change every 4 cycles
        step_seen = 0;
        go(2'b10, 4); go(2'b11, 4); go(2'b01, 4); go(2'b00, 4);
        check("up_steps", step_seen, 4);
        check("up_pos", int'(position), 4);
        check("up_dir", int'(up_down), 1);

        // clear to 0, then a single down step wraps
        tick(2'b00, 1'b1, 1'b0);
        step_seen = 0;
        go(2'b01, 4);
        check("wrap_pos", int'(position), 15);
        check("wrap_dir", int'(up_down), 0);
        check("wrap_steps", step_seen, 1);

        // 01 -> 00 -> 10, then illegal jump to 01
        go(2'b00, 4); go(2'b10, 4);
        step_seen = 0;
        go(2'b01, 4);
        check("ill_err", int'(error), 1);
        check("ill_steps", step_seen, 0);
        check("ill_pos", int'(position), 1);
        // error_clear on the edge where the next illegal jump registers
        tick(2'b10, 1'b0, 1'b0);
        tick(2'b10, 1'b0, 1'b0);
        tick(2'b10, 1'b0, 1'b1);
        check("set_wins", int'(error), 1);
        tick(2'b10, 1'b0, 1'b1);
        check("err_cleared", int'(error), 0);

        // up to 7, then clear on the edge of the next up step
        go(2'b11, 4); go(2'b01, 4); go(2'b00, 4); go(2'b10, 4); go(2'b11, 4); go(2'b01, 4);
        check("pre_clr_pos", int'(position), 7);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        check("clr_step", int'(step), 1);
        check("clr_pos", int'(position), 0);
        check("clr_dir", int'(up_down), 1);

        // reach position 9 with {A,B}=11, then reset while held
        go(2'b00, 3); go(2'b10, 4);
        tick(2'b10, 1'b1, 1'b0);
        go(2'b11, 4); go(2'b01, 4); go(2'b00, 4); go(2'b10, 4);
        go(2'b11, 4); go(2'b01, 4); go(2'b00, 4); go(2'b10, 4); go(2'b11, 4);
        check("pre_rst_pos", int'(position), 9);
        do_reset(2);
        step_seen = 0;
        go(2'b11, 10);
        check("rst11_pos", int'(position), 0);
        check("rst11_steps", step_seen, 0);
        check("rst11_err", int'(error), 0);

        // random walk: mostly legal moves, occasional illegal jumps, clears and resets
        for (int k = 0; k < 400; k++) begin
            int r;
            int hold;
            logic [1:0] nxt;
            r = $urandom_range(0, 99);
            if (r < 42)      nxt = succ(cur_ab, 1);
            else if (r < 84) nxt = succ(cur_ab, 3);
            else if (r < 92) nxt = succ(cur_ab, 2);
            else             nxt = cur_ab;
            if ($urandom_range(0, 99) < 2) do_reset($urandom_range(1, 3));
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++)
                tick(nxt, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Receive-side front end for the up/down position counters.
- Synchronises two quadrature inputs (A, B) and decodes each legal Gray-code transition into a one-cycle step pulse with an up_down direction level (1 = up, 0 = down), matching the counter convention.
- Keeps its own wrap-around position count and flags illegal double-bit transitions.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the synchroniser on each of quad_a and quad_b; minimum 2.
- POS_WIDTH, 4, width of the position counter.

Ports:
- clock  input  1  system clock; all flops update on the rising edge.
- reset  input  1  synchronous, active-high.
- quad_a  input  1  asynchronous quadrature channel A.
- quad_b  input  1  asynchronous quadrature channel B.
- clear  input  1  synchronous clear of position.
- error_clear  input  1  clears the sticky error flag.
- step  output  1  one-cycle pulse per legal transition.
- up_down  output  1  direction of the most recent legal step; 1 = up, 0 = down.
- position  output  POS_WIDTH  signed-agnostic wrap-around step count.
- error  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (synchronous, active-high; clock is clock):
  - step=0, up_down=1, position=0, error=0.
  - All synchroniser flops and the previous-state register are cleared.
  - FSM enters ARM.
- FSM has two states:
  - ARM: lasts exactly SYNC_STAGES+1 cycles after reset deasserts. The previous-state register tracks the synchronised {A,B} every cycle. No step, no error, no position change. clear and error_clear are still honoured.
  - RUN: entered after ARM completes. It is left only by reset. Reset asserted mid-operation returns the FSM to ARM from any state.
- Decode in RUN: cur = synchronised {A,B}; prev = cur from the previous cycle.
  - Up sequence: 00→10→11→01→00 (A leads B).
  - Down sequence: the reverse, 00→01→11→10→00.
  - cur == prev: no action.
  - Legal up transition: step=1 for one cycle, up_down=1, position+1.
  - Legal down transition: step=1 for one cycle, up_down=0, position−1.
  - Both bits change (00↔11, 01↔10): error set, no step, position and up_down unchanged, prev still updated to cur.
- Latency: an input change stable before edge k appears on the synchroniser output at edge k+SYNC_STAGES−1. step, up_down and position update at edge k+SYNC_STAGES. All outputs are registered.
- Back-to-back legal transitions on consecutive synchronised cycles each produce their own step, so step may stay high for multiple cycles.
- Position arithmetic: modulo 2^POS_WIDTH.
  - Up from all-ones wraps to 0.
  - Down from 0 wraps to all-ones.
- Priorities:
  - clear and step in the same cycle: position=0, step still pulses, up_down still updates.
  - error_clear and a new illegal transition in the same cycle: error=1 (set wins).
  - reset overrides everything.
- up_down is a held level; it changes only on a legal step or on reset.

Decomposition:
- Shared package quad_pkg holds:
  - 2-bit state constants QS_00, QS_10, QS_11, QS_01.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - FSM state encoding ST_ARM, ST_RUN.
- One natural sub-module: sync_chain (single-bit, SYNC_STAGES-deep, reset to 0), instantiated once each for quad_a and quad_b.
- Decode logic, arm counter, position register and error flag stay in quadrature_decoder.

Test Plan:
- Reset, hold A=B=0 for 10 cycles -> step never asserts, position=0, error=0, up_down=1.
- After ARM, drive {A,B} 00→10→11→01→00, one change every 4 cycles -> 4 step pulses, each 2 cycles after its change (SYNC_STAGES=2), up_down=1, position=4.
- From position=0, drive one down transition 00→01 -> position=15 (wrap), up_down=0, single step pulse.
- From {A,B}=10, jump to 01 -> error=1, no step, position unchanged. Then assert error_clear together with a further illegal jump 01→10 -> error stays 1. error_clear alone on the next cycle -> error=0.
- Assert clear in the same cycle a legal up step registers, with position=7 -> position=0, step=1, up_down=1.
- Assert reset while position=9 and A=1,B=1 are held; release -> position=0, no step during the 3 ARM cycles, no spurious step or error after ARM despite {A,B}=11.
